// File: rtl/credit_rr_port_scheduler_if.sv
// Handshake and beat bus between requesters, the port scheduler and the downstream buffer.
// The slave modport is the scheduler's view; master is the view of whatever drives it.
interface credit_rr_port_scheduler_if;
    logic [4:0]   io_in_valid;
    logic [4:0]   io_in_ready;
    logic [169:0] io_in_bits;
    logic         io_out_valid;
    logic [33:0]  io_out_bits;
    logic         io_out_last;
    logic [2:0]   io_chosen;
    logic         io_credit_return;
    logic         io_credit_overflow;

    modport slave (
        input  io_in_valid, io_in_bits, io_credit_return,
        output io_in_ready, io_out_valid, io_out_bits, io_out_last, io_chosen,
               io_credit_overflow
    );

    modport master (
        output io_in_valid, io_in_bits, io_credit_return,
        input  io_in_ready, io_out_valid, io_out_bits, io_out_last, io_chosen,
               io_credit_overflow
    );
endinterface

// File: rtl/credit_rr_port_scheduler.sv
// Five-way round-robin beat scheduler with 4-beat packet locking and a downstream
// credit counter; one registered beat per cycle toward the downstream buffer.
module credit_rr_port_scheduler #(
    parameter int unsigned NUM_CREDITS = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    credit_rr_port_scheduler_if.slave     io
);

    typedef enum logic [0:0] {StIdle, StLocked} state_e;

    state_e      state_q, state_d;
    logic [2:0]  last_grant_q, last_grant_d;
    logic [1:0]  beat_cnt_q, beat_cnt_d;
    logic [2:0]  lock_idx_q, lock_idx_d;
    logic [3:0]  credit_cnt_q, credit_cnt_d;
    logic        out_valid_q, out_valid_d;
    logic [33:0] out_bits_q, out_bits_d;
    logic        out_last_q, out_last_d;
    logic [2:0]  chosen_q, chosen_d;
    logic        overflow_q, overflow_d;

    logic        has_grant;
    logic [2:0]  grant_idx;
    logic [3:0]  cand;
    logic        accept;
    logic [33:0] beat;
    logic        is_last;

    // Grant selection: locked owner only, otherwise round-robin after last_grant.
    always_comb begin
        has_grant = 1'b0;
        grant_idx = 3'd0;
        cand      = 4'd0;
        if (state_q == StLocked) begin
            grant_idx = lock_idx_q;
            has_grant = io.io_in_valid[lock_idx_q];
        end else begin
            for (int unsigned i = 1; i <= 5; i++) begin
                cand = {1'b0, last_grant_q} + 4'(i);
                if (cand >= 4'd5) cand = cand - 4'd5;
                if (!has_grant && io.io_in_valid[cand[2:0]]) begin
                    has_grant = 1'b1;
                    grant_idx = cand[2:0];
                end
            end
        end
    end

    always_comb begin
        beat = '0;
        for (int k = 0; k < 5; k++) begin
            if (grant_idx == 3'(k)) beat = io.io_in_bits[34*k +: 34];
        end
    end

    assign accept         = has_grant && (credit_cnt_q != 4'd0);
    assign io.io_in_ready = accept ? (5'd1 << grant_idx) : 5'd0;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        lock_idx_d   = lock_idx_q;
        credit_cnt_d = credit_cnt_q;
        overflow_d   = overflow_q;
        is_last      = 1'b0;

        if (accept) begin
            if (state_q == StIdle) begin
                if (beat[1:0] == 2'b11) begin
                    state_d    = StLocked;
                    beat_cnt_d = 2'd1;
                    lock_idx_d = grant_idx;
                end else begin
                    is_last      = 1'b1;
                    last_grant_d = grant_idx;
                end
            end else begin
                beat_cnt_d = beat_cnt_q + 2'd1;
                if (beat_cnt_q == 2'd3) begin
                    is_last      = 1'b1;
                    state_d      = StIdle;
                    last_grant_d = lock_idx_q;
                end
            end
        end

        if (accept && !io.io_credit_return) begin
            credit_cnt_d = credit_cnt_q - 4'd1;
        end else if (!accept && io.io_credit_return) begin
            if (credit_cnt_q == 4'(NUM_CREDITS)) overflow_d = 1'b1;
            else credit_cnt_d = credit_cnt_q + 4'd1;
        end

        out_valid_d = accept;
        out_last_d  = accept && is_last;
        out_bits_d  = accept ? beat : out_bits_q;
        chosen_d    = accept ? grant_idx : chosen_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            last_grant_q <= 3'd4;
            beat_cnt_q   <= 2'd0;
            lock_idx_q   <= 3'd0;
            credit_cnt_q <= 4'(NUM_CREDITS);
            out_valid_q  <= 1'b0;
            out_bits_q   <= '0;
            out_last_q   <= 1'b0;
            chosen_q     <= 3'd0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
            lock_idx_q   <= lock_idx_d;
            credit_cnt_q <= credit_cnt_d;
            out_valid_q  <= out_valid_d;
            out_bits_q   <= out_bits_d;
            out_last_q   <= out_last_d;
            chosen_q     <= chosen_d;
            overflow_q   <= overflow_d;
        end
    end

    assign io.io_out_valid       = out_valid_q;
    assign io.io_out_bits        = out_bits_q;
    assign io.io_out_last        = out_last_q;
    assign io.io_chosen          = chosen_q;
    assign io.io_credit_overflow = overflow_q;

endmodule

// File: tb/tb_credit_rr_port_scheduler.sv
// Directed bench: stimulus pushes expected beats into a queue, a negedge monitor pops
// and compares every emitted beat; ready and overflow are checked directly.
module tb_credit_rr_port_scheduler;

    typedef struct packed {
        logic [33:0] bits;
        logic [2:0]  chosen;
        logic        last;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    exp_t exp_q[$];
    logic [33:0] tb_beat [5];

    credit_rr_port_scheduler_if u_if ();

    credit_rr_port_scheduler #(.NUM_CREDITS(4)) u_dut (
        .clk   (clk),
        .reset (reset),
        .io    (u_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [33:0] mk(input logic [2:0] src, input logic [2:0] dst,
                                       input logic [25:0] addr, input logic [1:0] pt);
        return {src, dst, addr, pt};
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // One cycle: drive inputs just after the edge, check ready, queue the expected beat.
    task automatic cyc(input logic [4:0] v, input logic ret, input logic [4:0] exp_rdy,
                       input logic exp_last);
        exp_t e;
        u_if.io_in_valid      = v;
        u_if.io_credit_return = ret;
        for (int k = 0; k < 5; k++) u_if.io_in_bits[34*k +: 34] = tb_beat[k];
        #2;
        check("in_ready", {29'd0, u_if.io_in_ready}, {29'd0, exp_rdy});
        for (int k = 0; k < 5; k++) begin
            if (exp_rdy[k]) begin
                e.bits   = tb_beat[k];
                e.chosen = 3'(k);
                e.last   = exp_last;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (u_if.io_out_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat actual=%h required=none", u_if.io_out_bits);
                end else begin
                    e = exp_q.pop_front();
                    check("out_bits", u_if.io_out_bits, e.bits);
                    check("out_chosen", {31'd0, u_if.io_chosen}, {31'd0, e.chosen});
                    check("out_last", {33'd0, u_if.io_out_last}, {33'd0, e.last});
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset = 1'b0;
        u_if.io_in_valid      = '0;
        u_if.io_in_bits       = '0;
        u_if.io_credit_return = 1'b0;
        for (int k = 0; k < 5; k++) tb_beat[k] = '0;
        #3;
        check("rst_out_valid", {33'd0, u_if.io_out_valid}, 34'd0);
        check("rst_out_bits", u_if.io_out_bits, 34'd0);
        check("rst_out_last", {33'd0, u_if.io_out_last}, 34'd0);
        check("rst_chosen", {31'd0, u_if.io_chosen}, 34'd0);
        check("rst_overflow", {33'd0, u_if.io_credit_overflow}, 34'd0);
        #19 reset = 1'b1;
        @(posedge clk);
        #1;

        // Full round robin, credits replenished each cycle.
        for (int k = 0; k < 5; k++) tb_beat[k] = mk(3'(k), 3'd7, 26'h100 + 26'(k), 2'b00);
        cyc(5'b11111, 1'b1, 5'b00001, 1'b1);
        cyc(5'b11111, 1'b1, 5'b00010, 1'b1);
        cyc(5'b11111, 1'b1, 5'b00100, 1'b1);
        cyc(5'b11111, 1'b1, 5'b01000, 1'b1);
        cyc(5'b11111, 1'b1, 5'b10000, 1'b1);
        cyc(5'b11111, 1'b1, 5'b00001, 1'b1);

        // 4-beat packet from req 2 with an owner stall; later beats' p_type ignored.
        tb_beat[0] = mk(3'd0, 3'd1, 26'h200, 2'b00);
        tb_beat[4] = mk(3'd4, 3'd1, 26'h204, 2'b10);
        tb_beat[2] = mk(3'd2, 3'd3, 26'h300, 2'b11);
        cyc(5'b10101, 1'b1, 5'b00100, 1'b0);
        tb_beat[2] = mk(3'd2, 3'd3, 26'h301, 2'b00);
        cyc(5'b10101, 1'b1, 5'b00100, 1'b0);
        cyc(5'b10001, 1'b0, 5'b00000, 1'b0);
        tb_beat[2] = mk(3'd2, 3'd3, 26'h302, 2'b11);
        cyc(5'b10101, 1'b1, 5'b00100, 1'b0);
        tb_beat[2] = mk(3'd2, 3'd3, 26'h303, 2'b01);
        cyc(5'b10101, 1'b1, 5'b00100, 1'b1);
        cyc(5'b10001, 1'b1, 5'b10000, 1'b1);
        cyc(5'b10001, 1'b1, 5'b00001, 1'b1);

        // Credit exhaustion with req 1 streaming, then a single return.
        for (int i = 0; i < 4; i++) begin
            tb_beat[1] = mk(3'd1, 3'd2, 26'h400 + 26'(i), 2'b00);
            cyc(5'b00010, 1'b0, 5'b00010, 1'b1);
        end
        cyc(5'b00010, 1'b0, 5'b00000, 1'b0);
        cyc(5'b00010, 1'b1, 5'b00000, 1'b0);
        tb_beat[1] = mk(3'd1, 3'd2, 26'h404, 2'b00);
        cyc(5'b00010, 1'b0, 5'b00010, 1'b1);
        cyc(5'b00010, 1'b0, 5'b00000, 1'b0);

        // Refill to 2, then 10 cycles of accept plus return; 2 credits remain after.
        cyc(5'b00000, 1'b1, 5'b00000, 1'b0);
        cyc(5'b00000, 1'b1, 5'b00000, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tb_beat[3] = mk(3'd3, 3'd0, 26'h500 + 26'(i), 2'b00);
            cyc(5'b01000, 1'b1, 5'b01000, 1'b1);
        end
        cyc(5'b01000, 1'b0, 5'b01000, 1'b1);
        cyc(5'b01000, 1'b0, 5'b01000, 1'b1);
        cyc(5'b01000, 1'b0, 5'b00000, 1'b0);
        check("no_overflow", {33'd0, u_if.io_credit_overflow}, 34'd0);
        for (int i = 0; i < 4; i++) cyc(5'b00000, 1'b1, 5'b00000, 1'b0);
        check("no_overflow_full", {33'd0, u_if.io_credit_overflow}, 34'd0);

        // Return at full credit: sticky overflow, count stays at 4.
        cyc(5'b00000, 1'b1, 5'b00000, 1'b0);
        check("overflow_set", {33'd0, u_if.io_credit_overflow}, 34'd1);
        for (int i = 0; i < 4; i++) begin
            tb_beat[0] = mk(3'd0, 3'd5, 26'h5a0 + 26'(i), 2'b01);
            cyc(5'b00001, 1'b0, 5'b00001, 1'b1);
        end
        cyc(5'b00001, 1'b0, 5'b00000, 1'b0);
        for (int i = 0; i < 4; i++) cyc(5'b00000, 1'b1, 5'b00000, 1'b0);
        check("overflow_sticky", {33'd0, u_if.io_credit_overflow}, 34'd1);

        // Reset in the middle of a 4-beat packet from req 3.
        tb_beat[3] = mk(3'd3, 3'd6, 26'h600, 2'b11);
        cyc(5'b01000, 1'b1, 5'b01000, 1'b0);
        tb_beat[3] = mk(3'd3, 3'd6, 26'h601, 2'b00);
        cyc(5'b01000, 1'b1, 5'b01000, 1'b0);
        u_if.io_in_valid = 5'b00000;
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("async_out_valid", {33'd0, u_if.io_out_valid}, 34'd0);
        check("async_out_bits", u_if.io_out_bits, 34'd0);
        check("async_chosen", {31'd0, u_if.io_chosen}, 34'd0);
        check("async_overflow", {33'd0, u_if.io_credit_overflow}, 34'd0);
        @(posedge clk);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
        for (int k = 0; k < 5; k++) tb_beat[k] = mk(3'(k), 3'd1, 26'h700 + 26'(k), 2'b00);
        cyc(5'b11111, 1'b1, 5'b00001, 1'b1);
        cyc(5'b11111, 1'b1, 5'b00010, 1'b1);
        cyc(5'b00000, 1'b0, 5'b00000, 1'b0);
        cyc(5'b00000, 1'b0, 5'b00000, 1'b0);

        check("queue_drained", 34'(exp_q.size()), 34'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
